// File: rtl/count_extender.sv
// Upper-count extension for a 4-bit upstream counter.
// It keeps the upper bits of the composite count, flags a sticky overflow, and
// queues {upper, counter} snapshots in a small first-word-fall-through FIFO.
// The FIFO has a registered head, valid and full, so the outputs have no
// combinational path from snap or snap_ready.
module count_extender #(
    parameter int UPPER_W = 12,
    parameter int DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 co,
    input  logic [3:0]           counter,
    input  logic                 snap,
    output logic [UPPER_W+3:0]   snap_data,
    output logic                 snap_valid,
    input  logic                 snap_ready,
    output logic                 full,
    output logic                 ovf,
    output logic [3:0]           drop_cnt,
    output logic [UPPER_W-1:0]   upper
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = UPPER_W + 4;
    localparam logic [AW:0] OCC_ONE  = (AW+1)'(1);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    // Upper count and overflow state
    logic [UPPER_W-1:0] upper_q, upper_d;
    logic               ovf_q, ovf_d;
    logic [3:0]         drop_q, drop_d;

    // FIFO state
    logic [DW-1:0]      mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      rd_next;
    logic [AW:0]        occ_q, occ_d;
    logic [DW-1:0]      head_q, head_d;
    logic               valid_q, valid_d;
    logic               full_q, full_d;

    // Per-cycle events
    logic               inc;
    logic               pop;
    logic               push;
    logic               drop;
    logic [DW-1:0]      push_data;

    // co by itself never advances the upper count; the enable must agree.
    assign inc       = en & co;
    // Pops are qualified by the registered valid, so popping an empty FIFO does nothing.
    assign pop       = valid_q & snap_ready;
    // A full FIFO still accepts a snapshot when the head leaves in the same cycle.
    assign push      = snap & (~full_q | pop);
    assign drop      = snap & full_q & ~pop;
    // Snapshot uses the pre-increment upper value, matching what the counter shows now.
    assign push_data = {upper_q, counter};
    assign rd_next   = rd_ptr_q + 1'b1;

    // Upper count, sticky overflow and saturating drop counter next-state
    always_comb begin
        upper_d = upper_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        if (inc) begin
            upper_d = upper_q + 1'b1;
            if (&upper_q) begin
                ovf_d = 1'b1;
            end
        end
        if (drop && (drop_q != 4'hF)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    // FIFO pointers, occupancy and registered head/valid/full next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        head_d   = head_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_next;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
        // The head only changes when the FIFO stays non-empty; otherwise it keeps the last value.
        if (occ_d != '0) begin
            if (pop) begin
                // Popping the only entry while pushing: the new snapshot becomes the head.
                if (occ_q == OCC_ONE) begin
                    head_d = push_data;
                end else begin
                    head_d = mem[rd_next];
                end
            end else if (occ_q == '0) begin
                head_d = push_data;
            end
        end
        valid_d = (occ_d != '0);
        full_d  = (occ_d == OCC_FULL);
    end

    // State registers; reset wins over every other event in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            upper_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= 4'h0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            upper_q  <= upper_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    // Storage entries; contents need no reset because occupancy gates their use
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Write this entry when it is the current write target
            always_ff @(posedge clk) begin
                if (!rst && push && (wr_ptr_q == AW'(gi))) begin
                    mem[gi] <= push_data;
                end
            end
        end
    endgenerate

    assign snap_data  = head_q;
    assign snap_valid = valid_q;
    assign full       = full_q;
    assign ovf        = ovf_q;
    assign drop_cnt   = drop_q;
    assign upper      = upper_q;

endmodule

// File: doc/count_extender.md
COUNT_EXTENDER -- requirements
Module: count_extender

Interface
REQ-001 Parameter UPPER_W, default 12, width of the upper count held in this block.
REQ-002 Parameter DEPTH, default 4, number of snapshot FIFO entries; power of two, at least 2.
REQ-003 clk  in  1  rising-edge clock, shared with the upstream 4-bit counter.
REQ-004 rst  in  1  synchronous, active-high reset, shared with the upstream counter.
REQ-005 en  in  1  the same enable that drives the upstream counter.
REQ-006 co  in  1  upstream carry-out, combinational, high whenever counter == 4'hF regardless of en.
REQ-007 counter  in  4  upstream count value.
REQ-008 snap  in  1  single-cycle snapshot request.
REQ-009 snap_data  out  UPPER_W+4  FIFO head, {upper, counter}.
REQ-010 snap_valid  out  1  FIFO non-empty.
REQ-011 snap_ready  in  1  consumer accepts the head this cycle.
REQ-012 full  out  1  FIFO holds DEPTH entries.
REQ-013 ovf  out  1  sticky overflow of the full 16-bit composite count.
REQ-014 drop_cnt  out  4  saturating count of snapshots lost while full.
REQ-015 upper  out  UPPER_W  current upper count, registered.

Function
REQ-016 Increment qualifier inc = en & co; co alone never advances upper.
REQ-017 On inc, upper <= upper + 1 modulo 2^UPPER_W, in the same edge at which the upstream counter wraps 15->0.
REQ-018 When inc is high and upper is all ones, upper wraps to 0 and ovf is set to 1; ovf holds at 1 until rst.
REQ-019 When snap is high, the block captures {upper, counter} as sampled at that edge (pre-increment values) and pushes it into the FIFO.
REQ-020 The FIFO is first-word-fall-through: snap_data is valid in the same cycle as snap_valid, and the first push appears at the outputs one cycle after snap.
REQ-021 A pop occurs on snap_valid & snap_ready; snap_data and snap_valid are undefined-free: snap_data holds the last value when the FIFO is empty, and snap_valid = 0.
REQ-022 A push and a pop in the same cycle leave the occupancy unchanged, and the order is preserved.
REQ-023 When full and a pop occurs in the same cycle as snap, the push is accepted.
REQ-024 When full, with no pop, and snap is high, the snapshot is discarded and drop_cnt increments, saturating at 15.
REQ-025 A pop while empty is ignored, with no pointer movement.
REQ-026 Occupancy width is log2(DEPTH)+1; full = (occupancy == DEPTH).
REQ-027 No combinational path exists from snap or snap_ready to any output except through registers; snap_valid and full are registered.

Reset
REQ-028 On rst at a rising edge: upper = 0, ovf = 0, drop_cnt = 0, FIFO empty, snap_valid = 0, full = 0, snap_data = 0.
REQ-029 rst takes priority over inc, snap and pop in the same cycle; a reset mid-operation discards all FIFO contents.
REQ-030 The first increment after reset requires the upstream counter to reach 15 with en high.

Verification
REQ-031 Reset, en = 1 for 16 cycles, upstream counting 0..15 -> upper = 1 after the edge on which counter = 15; co held high with en = 0 for 5 cycles -> upper unchanged.
REQ-032 UPPER_W = 12, preload by running 65535 enabled cycles -> upper = 12'hFFF, counter = 15, ovf = 0; one more enabled cycle -> upper = 0, ovf = 1; ovf remains 1 for the next 100 cycles.
REQ-033 snap at upper = 3, counter = 7, with snap_ready = 1 -> snap_valid = 1 the next cycle with snap_data = 16'h0037, then snap_valid = 0.
REQ-034 snap_ready = 0, 6 snap pulses, DEPTH = 4 -> full = 1 after the 4th, drop_cnt = 2, draining returns the first four captures in order.
REQ-035 Full FIFO, snap and snap_ready high in the same cycle -> occupancy stays 4, drop_cnt unchanged, the new entry appears last.
REQ-036 Two entries queued, rst pulsed for 1 cycle -> snap_valid = 0, upper = 0, drop_cnt = 0 on the next cycle.
